// File: rtl/kf8259_inta_pkg.sv
// Shared types and constants for the KF8259 INTA sequencer.
package kf8259_inta_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StInta1,
    StGap,
    StInta2,
    StDeliver
  } inta_state_e;

  localparam logic [7:0] SPURIOUS_VECTOR = 8'hFF;

endpackage

// File: rtl/kf8259_inta_sequencer_if.sv
// CPU/PIC-facing signal bundle of the INTA sequencer; slave is the sequencer side.
interface kf8259_inta_sequencer_if;

  logic       interrupt_to_cpu;
  logic       interrupt_enable;
  logic       cpu_interrupt_request;
  logic       cpu_interrupt_acknowledge;
  logic       interrupt_acknowledge_n;
  logic [7:0] pic_data_bus;
  logic       pic_data_bus_io;
  logic [7:0] cpu_vector;
  logic       cpu_vector_valid;
  logic       cpu_vector_spurious;
  logic       busy;

  modport slave (
    input  interrupt_to_cpu,
    input  interrupt_enable,
    input  cpu_interrupt_acknowledge,
    input  pic_data_bus,
    input  pic_data_bus_io,
    output cpu_interrupt_request,
    output interrupt_acknowledge_n,
    output cpu_vector,
    output cpu_vector_valid,
    output cpu_vector_spurious,
    output busy
  );

  modport master (
    output interrupt_to_cpu,
    output interrupt_enable,
    output cpu_interrupt_acknowledge,
    output pic_data_bus,
    output pic_data_bus_io,
    input  cpu_interrupt_request,
    input  interrupt_acknowledge_n,
    input  cpu_vector,
    input  cpu_vector_valid,
    input  cpu_vector_spurious,
    input  busy
  );

endinterface

// File: rtl/kf8259_inta_sequencer.sv
// Turns a CPU interrupt accept into the 8086 two-pulse INTA sequence and returns
// the vector byte the KF8259 drives during the second pulse.
module kf8259_inta_sequencer
  import kf8259_inta_pkg::*;
#(
  parameter int unsigned INTA_PULSE_CYCLES = 4,
  parameter int unsigned INTA_GAP_CYCLES   = 2
) (
  input logic                     clock,
  input logic                     reset_n,
  kf8259_inta_sequencer_if.slave  seq_if
);

  localparam int unsigned MaxCycles = (INTA_PULSE_CYCLES > INTA_GAP_CYCLES) ?
                                      INTA_PULSE_CYCLES : INTA_GAP_CYCLES;
  localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

  localparam logic [CntWidth-1:0] PulseLoad = CntWidth'(INTA_PULSE_CYCLES - 1);
  localparam logic [CntWidth-1:0] GapLoad   = CntWidth'(INTA_GAP_CYCLES - 1);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

  inta_state_e         state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                inta_n_q;
  logic                valid_q;
  logic                spurious_q;
  logic                busy_q;
  logic [7:0]          vector_q;

  logic request;
  logic accept;

  // The only unregistered output: follows the IF flag within the same cycle.
  assign request = (state_q == StRequest) && seq_if.interrupt_enable;
  assign accept  = request && seq_if.cpu_interrupt_acknowledge;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      inta_n_q   <= 1'b1;
      valid_q    <= 1'b0;
      spurious_q <= 1'b0;
      busy_q     <= 1'b0;
      vector_q   <= 8'h00;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (seq_if.interrupt_to_cpu) begin
            state_q <= StRequest;
            busy_q  <= 1'b1;
          end
        end
        StRequest: begin
          // An accepted acknowledge wins over INT falling in the same cycle.
          if (accept) begin
            state_q  <= StInta1;
            inta_n_q <= 1'b0;
            cnt_q    <= PulseLoad;
          end else if (!seq_if.interrupt_to_cpu) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StInta1: begin
          if (cnt_q == '0) begin
            state_q  <= StGap;
            inta_n_q <= 1'b1;
            cnt_q    <= GapLoad;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q  <= StInta2;
            inta_n_q <= 1'b0;
            cnt_q    <= PulseLoad;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StInta2: begin
          if (cnt_q == '0) begin
            state_q  <= StDeliver;
            inta_n_q <= 1'b1;
            valid_q  <= 1'b1;
            if (!seq_if.pic_data_bus_io) begin
              vector_q   <= seq_if.pic_data_bus;
              spurious_q <= 1'b0;
            end else begin
              vector_q   <= SPURIOUS_VECTOR;
              spurious_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StDeliver: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          inta_n_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign seq_if.cpu_interrupt_request   = request;
  assign seq_if.interrupt_acknowledge_n = inta_n_q;
  assign seq_if.cpu_vector              = vector_q;
  assign seq_if.cpu_vector_valid        = valid_q;
  assign seq_if.cpu_vector_spurious     = spurious_q;
  assign seq_if.busy                    = busy_q;

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Bench for the INTA sequencer: default-timing and P=1/G=1 instances checked against
// a cycle-number timeline model of the two-pulse acknowledge.
module tb_kf8259_inta_sequencer;

  localparam int PA = 4;
  localparam int GA = 2;
  localparam int PB = 1;
  localparam int GB = 1;

  logic clock;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  logic       obs_inta  [0:31];
  logic       obs_valid [0:31];
  logic       obs_spur  [0:31];
  logic       obs_busy  [0:31];
  logic [7:0] obs_vec   [0:31];

  kf8259_inta_sequencer_if ifa ();
  kf8259_inta_sequencer_if ifb ();

  kf8259_inta_sequencer #(
    .INTA_PULSE_CYCLES(PA),
    .INTA_GAP_CYCLES  (GA)
  ) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .seq_if (ifa)
  );

  kf8259_inta_sequencer #(
    .INTA_PULSE_CYCLES(PB),
    .INTA_GAP_CYCLES  (GB)
  ) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .seq_if (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Timeline model: cycle i counts from the accepting edge (cycle 0).
  function automatic logic exp_inta_n(input int p, input int g, input int i);
    return !((i >= 1 && i <= p) || (i >= p + g + 1 && i <= 2 * p + g));
  endfunction

  function automatic logic exp_valid(input int p, input int g, input int i);
    return (i == 2 * p + g + 1);
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int sel, input logic intr, input logic ie, input logic ack);
    if (sel == 0) begin
      ifa.interrupt_to_cpu          = intr;
      ifa.interrupt_enable          = ie;
      ifa.cpu_interrupt_acknowledge = ack;
    end else begin
      ifb.interrupt_to_cpu          = intr;
      ifb.interrupt_enable          = ie;
      ifb.cpu_interrupt_acknowledge = ack;
    end
  endtask

  task automatic drive_bus(input int sel, input logic [7:0] data, input logic io);
    if (sel == 0) begin
      ifa.pic_data_bus    = data;
      ifa.pic_data_bus_io = io;
    end else begin
      ifb.pic_data_bus    = data;
      ifb.pic_data_bus_io = io;
    end
  endtask

  task automatic sample(input int sel, output logic inta_n, output logic req,
                        output logic valid, output logic spur, output logic busy,
                        output logic [7:0] vec);
    if (sel == 0) begin
      inta_n = ifa.interrupt_acknowledge_n;
      req    = ifa.cpu_interrupt_request;
      valid  = ifa.cpu_vector_valid;
      spur   = ifa.cpu_vector_spurious;
      busy   = ifa.busy;
      vec    = ifa.cpu_vector;
    end else begin
      inta_n = ifb.interrupt_acknowledge_n;
      req    = ifb.cpu_interrupt_request;
      valid  = ifb.cpu_vector_valid;
      spur   = ifb.cpu_vector_spurious;
      busy   = ifb.busy;
      vec    = ifb.cpu_vector;
    end
  endtask

  // Call while ack is high in cycle 0; records cycles 1..2P+G+2 and plays the PIC,
  // which drives junk early in the second pulse and the real vector in its last cycle.
  task automatic run_seq(input int sel, input int p, input int g, input logic [7:0] vec,
                         input logic io_mode, input logic jitter);
    int n;
    logic ci, ce, a, b, c, d, e;
    logic [7:0] v;
    n  = 2 * p + g + 2;
    ci = (sel == 0) ? ifa.interrupt_to_cpu : ifb.interrupt_to_cpu;
    ce = (sel == 0) ? ifa.interrupt_enable : ifb.interrupt_enable;
    for (int i = 1; i <= n; i++) begin
      step();
      sample(sel, a, b, c, d, e, v);
      obs_inta[i]  = a;
      obs_valid[i] = c;
      obs_spur[i]  = d;
      obs_busy[i]  = e;
      obs_vec[i]   = v;
      if (jitter && i < n) drive(sel, 1'($urandom), 1'($urandom), 1'($urandom));
      else if (i == 1) drive(sel, ci, ce, 1'b0);
      if (!io_mode && i >= p + g + 1 && i <= 2 * p + g)
        drive_bus(sel, (i == 2 * p + g) ? vec : ~vec, 1'b0);
      else
        drive_bus(sel, 8'($urandom), 1'b1);
    end
  endtask

  task automatic test_reset;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    drive_bus(0, 8'h00, 1'b1);
    drive_bus(1, 8'h00, 1'b1);
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sample(s, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if ({inta_n, req, valid, spur, busy} !== 5'b10000) begin
        tests_failed++;
        $display("FAIL reset_ctrl dut%0d: got %b want 10000", s, {inta_n, req, valid, spur, busy});
      end
      tests_run++;
      if (vec !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_vector dut%0d: got %h want 00", s, vec);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if ({inta_n, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: got inta_n,busy=%b want 10", {inta_n, busy});
    end
  endtask

  task automatic test_basic;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec;
    drive(0, 1'b1, 1'b1, 1'b0);
    #1;
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if (req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_req_early: got %b want 0", req);
    end
    step();
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if ({req, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL basic_req_rise: got req,busy=%b want 11", {req, busy});
    end
    drive(0, 1'b1, 1'b1, 1'b1);
    run_seq(0, PA, GA, 8'h08, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tests_run++;
      if (obs_inta[i] !== exp_inta_n(PA, GA, i) || obs_valid[i] !== exp_valid(PA, GA, i)) begin
        tests_failed++;
        $display("FAIL basic_timeline cycle %0d: got inta_n=%b valid=%b want %b %b", i,
                 obs_inta[i], obs_valid[i], exp_inta_n(PA, GA, i), exp_valid(PA, GA, i));
      end
    end
    tests_run++;
    if (obs_vec[11] !== 8'h08 || obs_spur[11] !== 1'b0 || obs_vec[12] !== 8'h08) begin
      tests_failed++;
      $display("FAIL basic_vector: got %h spur=%b hold=%h want 08 0 08",
               obs_vec[11], obs_spur[11], obs_vec[12]);
    end
    tests_run++;
    if (obs_busy[11] !== 1'b1 || obs_busy[12] !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy: got c11=%b c12=%b want 1 0", obs_busy[11], obs_busy[12]);
    end
    step();
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if ({req, busy, inta_n} !== 3'b111) begin
      tests_failed++;
      $display("FAIL back_to_back_c13: got req,busy,inta_n=%b want 111", {req, busy, inta_n});
    end
    drive(0, 1'b0, 1'b1, 1'b0);
    step();
    step();
  endtask

  task automatic test_if_gate;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec, v;
    v = 8'($urandom);
    drive(0, 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b0, 1'b1);
      #1;
      sample(0, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if (req !== 1'b0) begin
        tests_failed++;
        $display("FAIL ifgate_req_masked: got %b want 0", req);
      end
      step();
      sample(0, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if ({inta_n, busy} !== 2'b11) begin
        tests_failed++;
        $display("FAIL ifgate_ack_ignored: got inta_n,busy=%b want 11", {inta_n, busy});
      end
    end
    drive(0, 1'b1, 1'b1, 1'b0);
    #1;
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if (req !== 1'b1) begin
      tests_failed++;
      $display("FAIL ifgate_req_same_cycle: got %b want 1", req);
    end
    drive(0, 1'b1, 1'b1, 1'b1);
    run_seq(0, PA, GA, v, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tests_run++;
      if (obs_inta[i] !== exp_inta_n(PA, GA, i) || obs_valid[i] !== exp_valid(PA, GA, i)) begin
        tests_failed++;
        $display("FAIL ifgate_timeline cycle %0d: got inta_n=%b valid=%b", i, obs_inta[i],
                 obs_valid[i]);
      end
    end
    tests_run++;
    if (obs_vec[11] !== v) begin
      tests_failed++;
      $display("FAIL ifgate_vector: got %h want %h", obs_vec[11], v);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_withdraw;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec;
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b1, 1'b0);
    step();
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if ({req, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL withdraw_idle: got req,busy=%b want 00", {req, busy});
    end
    for (int k = 0; k < 12; k++) begin
      drive(0, 1'b0, 1'b1, 1'($urandom));
      step();
      sample(0, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if ({inta_n, valid, busy} !== 3'b100) begin
        tests_failed++;
        $display("FAIL withdraw_quiet: got inta_n,valid,busy=%b want 100", {inta_n, valid, busy});
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_spurious;
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b1, 1'b1, 1'b1);
    run_seq(0, PA, GA, 8'h3C, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tests_run++;
      if (obs_valid[i] !== exp_valid(PA, GA, i)) begin
        tests_failed++;
        $display("FAIL spurious_valid cycle %0d: got %b want %b", i, obs_valid[i],
                 exp_valid(PA, GA, i));
      end
    end
    tests_run++;
    if (obs_vec[11] !== 8'hFF || obs_spur[11] !== 1'b1) begin
      tests_failed++;
      $display("FAIL spurious_vector: got %h spur=%b want ff 1", obs_vec[11], obs_spur[11]);
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset_mid;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec;
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b1, 1'b1, 1'b1);
    step();
    drive(0, 1'b1, 1'b1, 1'b0);
    repeat (7) step();
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if (inta_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got inta_n=%b want 0", inta_n);
    end
    #2;
    reset_n = 1'b0;
    #1;
    sample(0, inta_n, req, valid, spur, busy, vec);
    tests_run++;
    if ({inta_n, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rstmid_async: got inta_n,busy=%b want 10", {inta_n, busy});
    end
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      sample(0, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if ({inta_n, valid, busy} !== 3'b100) begin
        tests_failed++;
        $display("FAIL rstmid_after: got inta_n,valid,busy=%b want 100", {inta_n, valid, busy});
      end
    end
  endtask

  task automatic test_short_params;
    logic [7:0] v;
    v = 8'($urandom);
    drive(1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1, 1'b1, 1'b1, 1'b1);
    run_seq(1, PB, GB, v, 1'b0, 1'b1);
    for (int i = 1; i <= 2 * PB + GB + 2; i++) begin
      tests_run++;
      if (obs_inta[i] !== exp_inta_n(PB, GB, i) || obs_valid[i] !== exp_valid(PB, GB, i)) begin
        tests_failed++;
        $display("FAIL short_timeline cycle %0d: got inta_n=%b valid=%b want %b %b", i,
                 obs_inta[i], obs_valid[i], exp_inta_n(PB, GB, i), exp_valid(PB, GB, i));
      end
    end
    tests_run++;
    if (obs_vec[4] !== v || obs_spur[4] !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_vector: got %h spur=%b want %h 0", obs_vec[4], obs_spur[4], v);
    end
    drive(1, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_random;
    logic inta_n, req, valid, spur, busy;
    logic [7:0] vec, v, want_v;
    int sel, p, g, n;
    logic io, jit;
    for (int t = 0; t < 16; t++) begin
      sel    = t % 2;
      p      = (sel == 0) ? PA : PB;
      g      = (sel == 0) ? GA : GB;
      n      = 2 * p + g + 2;
      v      = 8'($urandom);
      io     = ($urandom_range(0, 3) == 0);
      jit    = 1'($urandom);
      want_v = io ? 8'hFF : v;
      repeat ($urandom_range(0, 2)) step();
      drive(sel, 1'b1, 1'b1, 1'b0);
      step();
      drive(sel, 1'b1, 1'b1, 1'b1);
      run_seq(sel, p, g, v, io, jit);
      for (int i = 1; i <= n; i++) begin
        tests_run++;
        if (obs_inta[i] !== exp_inta_n(p, g, i) || obs_valid[i] !== exp_valid(p, g, i)) begin
          tests_failed++;
          $display("FAIL random_timeline t%0d cycle %0d: got inta_n=%b valid=%b want %b %b", t,
                   i, obs_inta[i], obs_valid[i], exp_inta_n(p, g, i), exp_valid(p, g, i));
        end
      end
      tests_run++;
      if (obs_vec[n - 1] !== want_v || obs_spur[n - 1] !== io) begin
        tests_failed++;
        $display("FAIL random_vector t%0d: got %h spur=%b want %h %b", t, obs_vec[n - 1],
                 obs_spur[n - 1], want_v, io);
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
      step();
      step();
      sample(sel, inta_n, req, valid, spur, busy, vec);
      tests_run++;
      if ({inta_n, busy} !== 2'b10) begin
        tests_failed++;
        $display("FAIL random_return_idle t%0d: got inta_n,busy=%b want 10", t, {inta_n, busy});
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_if_gate();
    test_withdraw();
    test_spurious();
    test_reset_mid();
    test_short_params();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kf8259_inta_sequencer.md
# kf8259_inta_sequencer

Bridges the CPU core's interrupt handshake to the KF8259 programmable interrupt controller, sitting directly downstream of the controller's `interrupt_to_cpu` output. On a CPU acknowledge it generates the 8086-style two-pulse INTA sequence on `interrupt_acknowledge_n`, captures the vector byte the controller drives during the second pulse, and hands that byte to the CPU with a one-cycle valid strobe. Pulse and gap widths are parameterised to fit the core clock.

## Interface
- `INTA_PULSE_CYCLES`, default 4: cycles `interrupt_acknowledge_n` is held low per pulse; legal range ≥1.
- `INTA_GAP_CYCLES`, default 2: cycles held high between the two pulses; legal range ≥1.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `interrupt_to_cpu`  in  1  INT from the PIC.
- `interrupt_enable`  in  1  CPU IF flag; gates the request to the CPU.
- `cpu_interrupt_request`  out  1  pending interrupt offered to the CPU.
- `cpu_interrupt_acknowledge`  in  1  single-cycle accept from the CPU.
- `interrupt_acknowledge_n`  out  1  INTA to the PIC; registered.
- `pic_data_bus`  in  8  PIC `data_bus_out`.
- `pic_data_bus_io`  in  1  PIC `data_bus_io`; 0 means the PIC is driving.
- `cpu_vector`  out  8  captured vector; holds until the next capture.
- `cpu_vector_valid`  out  1  one-cycle strobe qualifying `cpu_vector`.
- `cpu_vector_spurious`  out  1  qualified by `cpu_vector_valid`; 1 means the PIC was not driving at sample time.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQUEST, INTA1, GAP, INTA2, DELIVER.
- IDLE:
  - `interrupt_to_cpu`=1 → REQUEST.
- REQUEST:
  - `cpu_interrupt_request` = `interrupt_enable`.
  - `interrupt_to_cpu` falls before acceptance → IDLE, request withdrawn.
  - Accept is `cpu_interrupt_acknowledge`=1 while `cpu_interrupt_request`=1. Accept → INTA1.
  - Acknowledge with the request deasserted is ignored.
  - If INT falls in the same cycle as an accepted acknowledge, the acknowledge wins.
- INTA1: INTA low for `INTA_PULSE_CYCLES`, then → GAP.
- GAP: INTA high for `INTA_GAP_CYCLES`, then → INTA2.
- INTA2: INTA low for `INTA_PULSE_CYCLES`, then → DELIVER.
  - On the last INTA2 cycle, capture `pic_data_bus` into `cpu_vector` if `pic_data_bus_io`=0.
  - Otherwise load 8'hFF and set `cpu_vector_spurious`=1.
- DELIVER: `cpu_vector_valid`=1 for exactly one cycle, then → IDLE.
- From INTA1 onward the sequence always completes. `interrupt_to_cpu`, `interrupt_enable` and further acknowledges are ignored until IDLE.
- Counter: one down-counter, width `$clog2(max(INTA_PULSE_CYCLES,INTA_GAP_CYCLES)+1)`.
  - Loaded with N−1 on state entry.
  - State advances when the counter reads 0.
  - No wrap-around is permitted.
- Reset values:
  - State IDLE.
  - `interrupt_acknowledge_n`=1.
  - `cpu_interrupt_request`=0, `cpu_vector_valid`=0, `cpu_vector_spurious`=0.
  - `cpu_vector`=8'h00, `busy`=0.
- Reset mid-sequence forces INTA high immediately (asynchronously) and aborts with no vector delivered.

## Timing
- Worked timeline for the defaults (P=4, G=2), cycle 0 = the accepting edge:
  - INTA low in cycles 1–4, high in 5–6, low in 7–10.
  - Capture at the end of cycle 10.
  - `cpu_vector_valid` in cycle 11; IDLE in cycle 12.
- Total latency from accept to valid = 2P+G+1 cycles.
- `cpu_interrupt_request` rises one cycle after `interrupt_to_cpu` is first sampled high in IDLE.
- Back-to-back operation: earliest re-request is cycle 13, provided INT is still high in cycle 12.
- All outputs are registered except `cpu_interrupt_request`, which is decoded from state AND `interrupt_enable`.

## Structure
- Shared package `kf8259_inta_pkg` holds:
  - the state enum;
  - `SPURIOUS_VECTOR` = 8'hFF.
- No sub-module is needed: FSM and counter live in one module.
- The top-level system instantiates the sequencer beside KF8259 and wires `interrupt_acknowledge_n`, `data_bus_out` and `data_bus_io` directly.

## Test plan
- INT=1, IF=1, PIC drives 8'h08 during INTA2, ack at cycle 0 → INTA low in cycles 1–4 and 7–10; `cpu_vector`=8'h08 with valid in cycle 11; spurious=0.
- IF=0 with INT held high → `cpu_interrupt_request`=0 and acks ignored; raising IF → request asserts the same cycle, and the sequence then runs normally.
- INT drops while in REQUEST before ack → IDLE next cycle; INTA never pulses; no valid.
- PIC not driving (`pic_data_bus_io`=1) during INTA2 → `cpu_vector`=8'hFF, spurious=1, valid for one cycle.
- Assert `reset_n`=0 in cycle 8 → INTA goes 1 asynchronously; after release, state is IDLE and no valid occurs.
- Parameters P=1, G=1 → INTA low in cycles 1 and 3, valid in cycle 4; INT pulsing during the sequence has no effect.
